// File: rtl/plru_lock_tracker.sv
// Pseudo-LRU victim selection with per-way locks: per-set MRU and lock
// vectors live in two 1R1W arrays with a registered read and write bypass.

module plru_lock_tracker_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array is built from flops and cleared by reset so every set starts with no MRU and no lock bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
    end
  end

endmodule

module plru_lock_tracker #(
  parameter int NUM_SETS        = 16,
  parameter int NUM_WAYS        = 4,
  parameter int SET_INDEX_WIDTH = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  parameter int WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fill_en,
  input  logic [SET_INDEX_WIDTH-1:0] fill_set,
  output logic [WAY_INDEX_WIDTH-1:0] fill_way,
  input  logic                       lock_en,
  input  logic                       lock_value,
  input  logic                       access_en,
  input  logic [SET_INDEX_WIDTH-1:0] access_set,
  input  logic                       access_update_en,
  input  logic [WAY_INDEX_WIDTH-1:0] access_update_way
);

  if (NUM_WAYS != 1 && NUM_WAYS != 2 && NUM_WAYS != 4 && NUM_WAYS != 8) begin : g_bad_ways
    $error("plru_lock_tracker: NUM_WAYS must be 1, 2, 4 or 8");
  end

  logic                       read_en;
  logic [SET_INDEX_WIDTH-1:0] read_set;
  logic [SET_INDEX_WIDTH-1:0] set_q;
  logic                       was_fill;
  logic                       was_lock;
  logic                       was_access;
  logic                       lock_value_q;
  logic [NUM_WAYS-1:0]        rd_mru;
  logic [NUM_WAYS-1:0]        rd_lock;
  logic [NUM_WAYS-1:0]        busy;
  logic [WAY_INDEX_WIDTH-1:0] new_mru;
  logic [NUM_WAYS-1:0]        new_oh;
  logic                       mru_we;
  logic                       lock_we;
  logic [NUM_WAYS-1:0]        mru_wdata;
  logic [NUM_WAYS-1:0]        lock_wdata;

  // Fill wins the single read port when both requests arrive together.
  assign read_en  = fill_en | access_en;
  assign read_set = fill_en ? fill_set : access_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      set_q        <= '0;
      was_fill     <= 1'b0;
      was_lock     <= 1'b0;
      was_access   <= 1'b0;
      lock_value_q <= 1'b0;
    end else begin
      was_fill     <= fill_en;
      was_lock     <= lock_en;
      was_access   <= access_en;
      lock_value_q <= lock_value;
      if (read_en) set_q <= read_set;
    end
  end

  assign busy = rd_mru | rd_lock;

  // NOTE: every combinational output gets a default before the loop, so no latch is inferred.
  always_comb begin
    fill_way = '0;
    if (NUM_WAYS > 1) begin
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
        if (!busy[i]) fill_way = WAY_INDEX_WIDTH'(i);
      end
    end
  end

  assign new_mru = was_fill ? fill_way : access_update_way;

  always_comb begin
    new_oh = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      new_oh[i] = (new_mru == WAY_INDEX_WIDTH'(i));
    end
  end

  assign mru_we  = was_fill | access_update_en;
  assign lock_we = was_lock & mru_we;

  // A saturated MRU vector restarts from the way just touched.
  always_comb begin
    mru_wdata = '0;
    if (NUM_WAYS > 1) begin
      mru_wdata = (&(rd_mru | new_oh | rd_lock)) ? new_oh : (rd_mru | new_oh);
    end
  end

  assign lock_wdata = lock_value_q ? (rd_lock | new_oh) : (rd_lock & ~new_oh);

  plru_lock_tracker_ram #(
    .DEPTH (NUM_SETS),
    .WIDTH (NUM_WAYS),
    .AW    (SET_INDEX_WIDTH)
  ) u_mru_ram (
    .clk   (clk),
    .reset (reset),
    .re    (read_en),
    .raddr (read_set),
    .rdata (rd_mru),
    .we    (mru_we),
    .waddr (set_q),
    .wdata (mru_wdata)
  );

  plru_lock_tracker_ram #(
    .DEPTH (NUM_SETS),
    .WIDTH (NUM_WAYS),
    .AW    (SET_INDEX_WIDTH)
  ) u_lock_ram (
    .clk   (clk),
    .reset (reset),
    .re    (read_en),
    .raddr (read_set),
    .rdata (rd_lock),
    .we    (lock_we),
    .waddr (set_q),
    .wdata (lock_wdata)
  );

  a_update_follows_access : assert property (
    @(posedge clk) disable iff (!reset) access_update_en |-> was_access
  ) else $error("plru_lock_tracker: access_update_en without a preceding access_en");

endmodule

// File: tb/tb_plru_lock_tracker.sv
// Self-checking bench for plru_lock_tracker: directed scenarios plus random
// traffic compared against a per-set victim/MRU/lock reference model.

module tb_plru_lock_tracker;

  localparam int NS = 16;
  localparam int NW = 4;

  logic       clk;
  logic       reset;
  logic       fill_en;
  logic [3:0] fill_set;
  logic [1:0] fill_way;
  logic       lock_en;
  logic       lock_value;
  logic       access_en;
  logic [3:0] access_set;
  logic       access_update_en;
  logic [1:0] access_update_way;

  int errors;
  int checks;

  bit [NW-1:0] m_mru  [NS];
  bit [NW-1:0] m_lock [NS];

  plru_lock_tracker #(
    .NUM_SETS (NS),
    .NUM_WAYS (NW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .fill_en           (fill_en),
    .fill_set          (fill_set),
    .fill_way          (fill_way),
    .lock_en           (lock_en),
    .lock_value        (lock_value),
    .access_en         (access_en),
    .access_set        (access_set),
    .access_update_en  (access_update_en),
    .access_update_way (access_update_way)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model_clear();
    for (int s = 0; s < NS; s++) begin
      m_mru[s]  = '0;
      m_lock[s] = '0;
    end
  endfunction

  // Record a use of way w in set s; optionally lock or unlock it.
  function automatic void model_touch(int s, int w, bit le, bit lv);
    bit [NW-1:0] oh;
    oh = '0;
    oh[w] = 1'b1;
    if ((m_mru[s] | oh | m_lock[s]) == {NW{1'b1}}) m_mru[s] = oh;
    else m_mru[s] = m_mru[s] | oh;
    if (le) begin
      if (lv) m_lock[s] = m_lock[s] | oh;
      else    m_lock[s] = m_lock[s] & ~oh;
    end
  endfunction

  // Victim = lowest way neither recently used nor locked, else way 0.
  function automatic int model_fill(int s, bit le, bit lv);
    int v;
    v = 0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (!m_mru[s][i] && !m_lock[s][i]) v = i;
    end
    model_touch(s, v, le, lv);
    return v;
  endfunction

  // ---------------- drivers (start and end at a negedge) ----------------
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_fill(input int s, input bit le, input bit lv, output int w);
    fill_en = 1'b1; fill_set = 4'(s); lock_en = le; lock_value = lv;
    @(posedge clk);
    @(negedge clk);
    fill_en = 1'b0; lock_en = 1'b0; lock_value = 1'b0;
    w = int'(fill_way);
  endtask

  task automatic do_access(input int s, input bit le, input bit lv, input bit hit, input int way);
    access_en = 1'b1; access_set = 4'(s); lock_en = le; lock_value = lv;
    @(posedge clk);
    @(negedge clk);
    access_en = 1'b0; lock_en = 1'b0; lock_value = 1'b0;
    access_update_en = hit; access_update_way = 2'(way);
    @(posedge clk);
    @(negedge clk);
    access_update_en = 1'b0;
  endtask

  // Hit update overlapped with the read of a following fill.
  task automatic do_access_fill(input int s, input int way, input bit le, input bit lv,
                                input int s2, input bit le2, input bit lv2, output int w);
    access_en = 1'b1; access_set = 4'(s); lock_en = le; lock_value = lv;
    @(posedge clk);
    @(negedge clk);
    access_en = 1'b0;
    access_update_en = 1'b1; access_update_way = 2'(way);
    fill_en = 1'b1; fill_set = 4'(s2); lock_en = le2; lock_value = lv2;
    @(posedge clk);
    @(negedge clk);
    access_update_en = 1'b0; fill_en = 1'b0; lock_en = 1'b0; lock_value = 1'b0;
    w = int'(fill_way);
  endtask

  // Fill and access requested together; optional hit arrives next cycle.
  task automatic do_fill_and_access(input int sf, input int sa, input bit le, input bit lv,
                                    input bit upd, input int way, output int w);
    fill_en = 1'b1; fill_set = 4'(sf); access_en = 1'b1; access_set = 4'(sa);
    lock_en = le; lock_value = lv;
    @(posedge clk);
    @(negedge clk);
    fill_en = 1'b0; access_en = 1'b0; lock_en = 1'b0; lock_value = 1'b0;
    w = int'(fill_way);
    access_update_en = upd; access_update_way = 2'(way);
    @(posedge clk);
    @(negedge clk);
    access_update_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int w;
    reset = 1'b0;
    idle(3);
    checks++;
    if (fill_way !== 2'd0) begin
      errors++; $display("FAIL reset_hold: fill_way=%0d expected 0", fill_way);
    end
    reset = 1'b1;
    idle(1);
    checks++;
    if (fill_way !== 2'd0) begin
      errors++; $display("FAIL reset_release: fill_way=%0d expected 0", fill_way);
    end
    do_fill(0, 0, 0, w);
    checks++;
    if (w != model_fill(0, 0, 0) || w != 0) begin
      errors++; $display("FAIL reset_first_fill: fill_way=%0d expected 0", w);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
    int w;
    int e;
    for (int i = 0; i < 6; i++) begin
      do_fill(3, 0, 0, w);
      e = model_fill(3, 0, 0);
      checks++;
      if (w != exp_seq[i] || w != e) begin
        errors++; $display("FAIL back_to_back[%0d]: fill_way=%0d expected %0d", i, w, exp_seq[i]);
      end
    end
    idle(1);
  endtask

  task automatic test_access_update();
    int w;
    do_access(5, 0, 0, 1, 2);
    model_touch(5, 2, 0, 0);
    do_fill(5, 0, 0, w);
    checks++;
    if (w != 0 || w != model_fill(5, 0, 0)) begin
      errors++; $display("FAIL access_update: fill_way=%0d expected 0", w);
    end
    do_access(5, 0, 0, 0, 3);
    do_fill(5, 0, 0, w);
    checks++;
    if (w != 1 || w != model_fill(5, 0, 0)) begin
      errors++; $display("FAIL access_miss_no_write: fill_way=%0d expected 1", w);
    end
    idle(1);
  endtask

  task automatic test_lock_skip();
    int exp_seq[5] = '{0, 1, 2, 3, 1};
    int w;
    int e;
    for (int i = 0; i < 5; i++) begin
      do_fill(7, i == 0, i == 0, w);
      e = model_fill(7, i == 0, i == 0);
      checks++;
      if (w != exp_seq[i] || w != e) begin
        errors++; $display("FAIL lock_skip[%0d]: fill_way=%0d expected %0d", i, w, exp_seq[i]);
      end
    end
    idle(1);
  endtask

  task automatic test_lock_unlock();
    int w;
    int e;
    for (int i = 0; i < 4; i++) begin
      do_fill(1, 1, 1, w);
      e = model_fill(1, 1, 1);
      checks++;
      if (w != i || w != e) begin
        errors++; $display("FAIL lock_all[%0d]: fill_way=%0d expected %0d", i, w, i);
      end
    end
    do_fill(1, 0, 0, w);
    e = model_fill(1, 0, 0);
    checks++;
    if (w != 0 || w != e) begin
      errors++; $display("FAIL all_locked: fill_way=%0d expected 0", w);
    end
    do_access(1, 1, 0, 1, 2);
    model_touch(1, 2, 1, 0);
    // Moving the MRU mark off way 2 leaves it as the only free way.
    do_access(1, 0, 0, 1, 0);
    model_touch(1, 0, 0, 0);
    do_fill(1, 0, 0, w);
    e = model_fill(1, 0, 0);
    checks++;
    if (w != 2 || w != e) begin
      errors++; $display("FAIL unlock_way2: fill_way=%0d expected 2", w);
    end
    idle(1);
  endtask

  task automatic test_fill_priority();
    int w;
    int e;
    do_fill(9, 0, 0, w); void'(model_fill(9, 0, 0));
    do_fill(9, 0, 0, w); void'(model_fill(9, 0, 0));
    do_fill(2, 0, 0, w); void'(model_fill(2, 0, 0));
    do_fill_and_access(2, 9, 0, 0, 1, 3, w);
    e = model_fill(2, 0, 0);
    checks++;
    if (w != 1 || w != e) begin
      errors++; $display("FAIL fill_wins_read: fill_way=%0d expected 1", w);
    end
    do_fill(9, 0, 0, w);
    e = model_fill(9, 0, 0);
    checks++;
    if (w != 2 || w != e) begin
      errors++; $display("FAIL access_set_untouched: fill_way=%0d expected 2", w);
    end
    do_fill(2, 0, 0, w);
    e = model_fill(2, 0, 0);
    checks++;
    if (w != 2 || w != e) begin
      errors++; $display("FAIL fill_way_wins_update: fill_way=%0d expected 2", w);
    end
    idle(1);
  endtask

  task automatic test_reset_after_fill();
    int w;
    do_fill(4, 1, 1, w); void'(model_fill(4, 1, 1));
    fill_en = 1'b1; fill_set = 4'd4;
    @(posedge clk);
    @(negedge clk);
    fill_en = 1'b0;
    reset = 1'b0;
    model_clear();
    idle(2);
    checks++;
    if (fill_way !== 2'd0) begin
      errors++; $display("FAIL reset_mid_fill: fill_way=%0d expected 0", fill_way);
    end
    reset = 1'b1;
    idle(1);
    do_fill(4, 0, 0, w);
    checks++;
    if (w != 0 || w != model_fill(4, 0, 0)) begin
      errors++; $display("FAIL fill_after_reset: fill_way=%0d expected 0", w);
    end
    do_fill(4, 0, 0, w);
    checks++;
    if (w != 1 || w != model_fill(4, 0, 0)) begin
      errors++; $display("FAIL fill_after_reset2: fill_way=%0d expected 1", w);
    end
    idle(1);
  endtask

  task automatic test_random();
    int w;
    int e;
    int s;
    int s2;
    int op;
    int way;
    bit le;
    bit lv;
    bit hit;
    for (int n = 0; n < 400; n++) begin
      s   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, NS - 1);
      s2  = ($urandom_range(0, 1) == 1) ? s : $urandom_range(0, NS - 1);
      op  = $urandom_range(0, 5);
      way = $urandom_range(0, NW - 1);
      le  = ($urandom_range(0, 3) == 0);
      lv  = ($urandom_range(0, 1) == 1);
      case (op)
        0, 1: begin
          do_fill(s, le, lv, w);
          e = model_fill(s, le, lv);
          checks++;
          if (w != e) begin
            errors++; $display("FAIL rand_fill[%0d] set %0d: fill_way=%0d expected %0d", n, s, w, e);
          end
        end
        2: begin
          do_access(s, le, lv, 1, way);
          model_touch(s, way, le, lv);
        end
        3: begin
          hit = ($urandom_range(0, 1) == 1);
          do_access(s, le, lv, hit, way);
          if (hit) model_touch(s, way, le, lv);
        end
        4: begin
          do_access_fill(s, way, le, lv, s2, 0, 0, w);
          model_touch(s, way, le, lv);
          e = model_fill(s2, 0, 0);
          checks++;
          if (w != e) begin
            errors++; $display("FAIL rand_overlap[%0d] set %0d: fill_way=%0d expected %0d", n, s2, w, e);
          end
        end
        default: begin
          do_fill_and_access(s, s2, le, lv, ($urandom_range(0, 1) == 1), way, w);
          e = model_fill(s, le, lv);
          checks++;
          if (w != e) begin
            errors++; $display("FAIL rand_fill_access[%0d] set %0d: fill_way=%0d expected %0d", n, s, w, e);
          end
        end
      endcase
      if ($urandom_range(0, 7) == 0) idle(1);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    fill_en = 1'b0; fill_set = '0; lock_en = 1'b0; lock_value = 1'b0;
    access_en = 1'b0; access_set = '0; access_update_en = 1'b0; access_update_way = '0;
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_access_update();
    test_lock_skip();
    test_lock_unlock();
    test_fill_priority();
    test_reset_after_fill();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
